cell_draw_cmd: RTL and testbench

//  Downstream of the map scanner: takes one changed cell (diff strobe, x, y, obj_code) and

---
 rtl/cell_draw_cmd.sv | 236 +++++++++++++++++++++++
 tb/tb_cell_draw_cmd.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/cell_draw_cmd.sv
// Paints one 20x20 map cell on a 320x240 LCD over an 8080-style 8-bit write bus.
// Optional feature macro: DRAW_GRID_EN (grid-coloured right column and bottom row of each cell).
module cell_draw_cmd #(
  parameter int CELL_PX = 20,
  parameter int MAX_ROW = 11
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       diff,
  input  logic [3:0] x,
  input  logic [3:0] y,
  input  logic [2:0] obj_code,
  output logic       cmd_done,
  output logic       busy,
  output logic       lcd_csx,
  output logic       lcd_dcx,
  output logic       lcd_wr_n,
  output logic [7:0] lcd_data,
  output logic [3:0] dbg_state
);

  // Handshake: diff is sampled only while idle; cmd_done pulses once per
  // accepted request (painted or dropped); busy covers accept through cmd_done.
  typedef enum logic [3:0] {
    S_IDLE, S_LOAD, S_CASET_CMD, S_CASET_DAT, S_PASET_CMD,
    S_PASET_DAT, S_RAMWR_CMD, S_PIXEL, S_DONE
  } state_t;

  localparam int CW = (CELL_PX > 1) ? $clog2(CELL_PX) : 1;
  localparam logic [CW-1:0] LAST = CW'(CELL_PX - 1);
  localparam logic [15:0] GRID_COLOUR = 16'h2104;

  state_t         state;
  logic [3:0]     cx, cy;
  logic [15:0]    colour;
  logic [1:0]     idx;
  logic           phase;
  logic           lo;
  logic [CW-1:0]  col, row;

  logic [15:0]    xs, xe, ys, ye;
  logic           adv_wrap;
  logic [CW-1:0]  adv_col, adv_row;
  logic [15:0]    cur_pix, adv_pix, first_pix;

  state_t         nxt_state;
  logic [7:0]     nxt_data;
  logic           nxt_dcx;
  logic [1:0]     nxt_idx;
  logic           nxt_lo;
  logic [CW-1:0]  nxt_col, nxt_row;
  logic           last_byte;

  assign dbg_state = state;

  assign xs = 16'(cx) * 16'(CELL_PX);
  assign xe = xs + 16'(CELL_PX - 1);
  assign ys = 16'(cy) * 16'(CELL_PX);
  assign ye = ys + 16'(CELL_PX - 1);

  assign adv_wrap = (col == LAST);
  assign adv_col  = adv_wrap ? '0 : col + 1'b1;
  assign adv_row  = adv_wrap ? row + 1'b1 : row;

`ifdef DRAW_GRID_EN
  assign cur_pix   = (col == LAST || row == LAST) ? GRID_COLOUR : colour;
  assign adv_pix   = (adv_col == LAST || adv_row == LAST) ? GRID_COLOUR : colour;
  assign first_pix = (LAST == '0) ? GRID_COLOUR : colour;
`else
  assign cur_pix   = colour;
  assign adv_pix   = colour;
  assign first_pix = colour;
`endif

  function automatic logic [15:0] lut(input logic [2:0] code);
    case (code)
      3'd0:    lut = 16'h0000;
      3'd1:    lut = 16'h07E0;
      3'd2:    lut = 16'h03E0;
      3'd3:    lut = 16'hF800;
      3'd4:    lut = 16'hFFFF;
      default: lut = 16'hF81F;
    endcase
  endfunction

  function automatic logic [7:0] win_byte(input logic [15:0] s, input logic [15:0] e,
                                          input logic [1:0] i);
    case (i)
      2'd0:    win_byte = s[15:8];
      2'd1:    win_byte = s[7:0];
      2'd2:    win_byte = e[15:8];
      default: win_byte = e[7:0];
    endcase
  endfunction

  // Next byte to present once the current byte has finished its second phase.
  always_comb begin
    nxt_state = state;
    nxt_data  = lcd_data;
    nxt_dcx   = 1'b1;
    nxt_idx   = idx;
    nxt_lo    = lo;
    nxt_col   = col;
    nxt_row   = row;
    last_byte = 1'b0;
    case (state)
      S_LOAD: begin
        nxt_state = S_CASET_CMD;
        nxt_data  = 8'h2A;
        nxt_dcx   = 1'b0;
      end
      S_CASET_CMD: begin
        nxt_state = S_CASET_DAT;
        nxt_idx   = 2'd0;
        nxt_data  = win_byte(xs, xe, 2'd0);
      end
      S_CASET_DAT: begin
        if (idx == 2'd3) begin
          nxt_state = S_PASET_CMD;
          nxt_data  = 8'h2B;
          nxt_dcx   = 1'b0;
        end else begin
          nxt_idx  = idx + 2'd1;
          nxt_data = win_byte(xs, xe, idx + 2'd1);
        end
      end
      S_PASET_CMD: begin
        nxt_state = S_PASET_DAT;
        nxt_idx   = 2'd0;
        nxt_data  = win_byte(ys, ye, 2'd0);
      end
      S_PASET_DAT: begin
        if (idx == 2'd3) begin
          nxt_state = S_RAMWR_CMD;
          nxt_data  = 8'h2C;
          nxt_dcx   = 1'b0;
        end else begin
          nxt_idx  = idx + 2'd1;
          nxt_data = win_byte(ys, ye, idx + 2'd1);
        end
      end
      S_RAMWR_CMD: begin
        nxt_state = S_PIXEL;
        nxt_lo    = 1'b0;
        nxt_col   = '0;
        nxt_row   = '0;
        nxt_data  = first_pix[15:8];
      end
      S_PIXEL: begin
        if (!lo) begin
          nxt_lo   = 1'b1;
          nxt_data = cur_pix[7:0];
        end else if (col == LAST && row == LAST) begin
          last_byte = 1'b1;
        end else begin
          nxt_lo   = 1'b0;
          nxt_col  = adv_col;
          nxt_row  = adv_row;
          nxt_data = adv_pix[15:8];
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      cx       <= '0;
      cy       <= '0;
      colour   <= '0;
      idx      <= '0;
      phase    <= 1'b0;
      lo       <= 1'b0;
      col      <= '0;
      row      <= '0;
      cmd_done <= 1'b0;
      busy     <= 1'b0;
      lcd_csx  <= 1'b1;
      lcd_dcx  <= 1'b1;
      lcd_wr_n <= 1'b1;
      lcd_data <= 8'h00;
    end else begin
      cmd_done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (diff) begin
            cx     <= x;
            cy     <= y;
            colour <= lut(obj_code);
            state  <= S_LOAD;
          end
        end
        S_LOAD: begin
          busy <= 1'b1;
          if (cy > 4'(MAX_ROW)) begin
            cmd_done <= 1'b1;
            state    <= S_DONE;
          end else begin
            lcd_csx  <= 1'b0;
            lcd_wr_n <= 1'b0;
            lcd_dcx  <= nxt_dcx;
            lcd_data <= nxt_data;
            phase    <= 1'b1;
            state    <= nxt_state;
          end
        end
        S_DONE: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: begin
          if (phase) begin
            lcd_wr_n <= 1'b1;
            phase    <= 1'b0;
          end else if (last_byte) begin
            lcd_csx  <= 1'b1;
            cmd_done <= 1'b1;
            state    <= S_DONE;
          end else begin
            lcd_wr_n <= 1'b0;
            lcd_dcx  <= nxt_dcx;
            lcd_data <= nxt_data;
            idx      <= nxt_idx;
            lo       <= nxt_lo;
            col      <= nxt_col;
            row      <= nxt_row;
            phase    <= 1'b1;
            state    <= nxt_state;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cell_draw_cmd.sv
// Randomized and directed bench for cell_draw_cmd against a byte-stream reference model.
module tb_cell_draw_cmd;

  localparam int W    = 9;
  localparam int CPX  = 20;
  localparam int NBYT = 11 + 2 * CPX * CPX;

  logic       clk;
  logic       rst;
  logic       diff;
  logic [3:0] x, y;
  logic [2:0] obj_code;
  logic       cmd_done, busy, lcd_csx, lcd_dcx, lcd_wr_n;
  logic [7:0] lcd_data;
  logic [3:0] dbg_state;

  logic [W-1:0] exp_q[$];
  int total = 0;
  int bad   = 0;

  cell_draw_cmd dut (
    .clk(clk), .rst(rst), .diff(diff), .x(x), .y(y), .obj_code(obj_code),
    .cmd_done(cmd_done), .busy(busy), .lcd_csx(lcd_csx), .lcd_dcx(lcd_dcx),
    .lcd_wr_n(lcd_wr_n), .lcd_data(lcd_data), .dbg_state(dbg_state)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, want, $time);
    end
  endtask

  function automatic logic [15:0] ref_colour(input int obj);
    logic [15:0] tab [8];
    tab = '{16'h0000, 16'h07E0, 16'h03E0, 16'hF800, 16'hFFFF, 16'hF81F, 16'hF81F, 16'hF81F};
    return tab[obj];
  endfunction

  task automatic build_exp(input int cx, input int cy, input int obj);
    int xs, xe, ys, ye;
    logic [15:0] c;
    xs = cx * CPX; xe = xs + CPX - 1;
    ys = cy * CPX; ye = ys + CPX - 1;
    exp_q.delete();
    exp_q.push_back({1'b0, 8'h2A});
    exp_q.push_back({1'b1, 8'(xs >> 8)}); exp_q.push_back({1'b1, 8'(xs)});
    exp_q.push_back({1'b1, 8'(xe >> 8)}); exp_q.push_back({1'b1, 8'(xe)});
    exp_q.push_back({1'b0, 8'h2B});
    exp_q.push_back({1'b1, 8'(ys >> 8)}); exp_q.push_back({1'b1, 8'(ys)});
    exp_q.push_back({1'b1, 8'(ye >> 8)}); exp_q.push_back({1'b1, 8'(ye)});
    exp_q.push_back({1'b0, 8'h2C});
    for (int p = 0; p < CPX * CPX; p++) begin
      c = ref_colour(obj);
`ifdef DRAW_GRID_EN
      if ((p % CPX) == CPX - 1 || (p / CPX) == CPX - 1) c = 16'h2104;
`endif
      exp_q.push_back({1'b1, c[15:8]});
      exp_q.push_back({1'b1, c[7:0]});
    end
  endtask

  // Starts at a negedge; returns at the negedge of the cmd_done cycle.
  task automatic run_req(input int rx, input int ry, input int ro, input int lat, input int inject_at);
    int bn;
    logic [W-1:0] prev, bus;
    bn = (ry > 11) ? 0 : NBYT;
    if (bn > 0) build_exp(rx, ry, ro);
    else exp_q.delete();
    x = 4'(rx); y = 4'(ry); obj_code = 3'(ro); diff = 1'b1;
    repeat (lat) @(posedge clk);
    @(negedge clk);
    diff = 1'b0;
    x = 4'($urandom_range(0, 15)); y = 4'($urandom_range(0, 15)); obj_code = 3'($urandom_range(0, 7));
    prev = '0;
    for (int t = 1; t <= 2 * bn + 1; t++) begin
      @(negedge clk);
      diff = (t == inject_at);
      if (t == inject_at) begin
        x = 4'($urandom_range(0, 15)); y = 4'($urandom_range(0, 11)); obj_code = 3'($urandom_range(0, 7));
      end
      bus = {lcd_dcx, lcd_data};
      chk("wr_n", 16'(lcd_wr_n), 16'(!((t % 2 == 1) && (t < 2 * bn))));
      chk("csx", 16'(lcd_csx), 16'(t > 2 * bn));
      chk("busy", 16'(busy), 16'd1);
      chk("cmd_done", 16'(cmd_done), 16'(t == 2 * bn + 1));
      if (lcd_wr_n === 1'b0) begin
        if (exp_q.size() > 0) chk("byte", 16'(bus), 16'(exp_q.pop_front()));
        else chk("extra_byte", 16'd1, 16'd0);
      end
      if ((t % 2 == 0) && (t <= 2 * bn)) chk("hold", 16'(bus), 16'(prev));
      prev = bus;
    end
    chk("bytes_left", 16'(exp_q.size()), 16'd0);
  endtask

  task automatic idle_chk();
    @(negedge clk);
    chk("idle_done", 16'(cmd_done), 16'd0);
    chk("idle_busy", 16'(busy), 16'd0);
    chk("idle_csx", 16'(lcd_csx), 16'd1);
    chk("idle_wr_n", 16'(lcd_wr_n), 16'd1);
  endtask

  initial begin
    rst = 1'b1; diff = 1'b0; x = '0; y = '0; obj_code = '0;
    repeat (3) @(negedge clk);
    chk("rst_done", 16'(cmd_done), 16'd0);
    chk("rst_busy", 16'(busy), 16'd0);
    chk("rst_csx", 16'(lcd_csx), 16'd1);
    chk("rst_dcx", 16'(lcd_dcx), 16'd1);
    chk("rst_wr_n", 16'(lcd_wr_n), 16'd1);
    chk("rst_data", 16'(lcd_data), 16'd0);
    rst = 1'b0;
    @(negedge clk);

    run_req(4, 4, 1, 1, 0);   idle_chk();
    run_req(15, 11, 4, 1, 0); idle_chk();
    run_req(3, 12, 2, 1, 0);  idle_chk();
    run_req(2, 7, 3, 1, 100);
    run_req(9, 1, 5, 2, 0);   idle_chk();

    repeat (6) begin
      run_req($urandom_range(0, 15), $urandom_range(0, 13), $urandom_range(0, 7), 1, 0);
      idle_chk();
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end

    // Asynchronous reset in the middle of a pixel stream.
    x = 4'd6; y = 4'd2; obj_code = 3'd3; diff = 1'b1;
    @(posedge clk);
    @(negedge clk);
    diff = 1'b0;
    repeat (37) @(negedge clk);
    chk("pre_rst_csx", 16'(lcd_csx), 16'd0);
    chk("pre_rst_wr_n", 16'(lcd_wr_n), 16'd0);
    #1 rst = 1'b1;
    #1;
    chk("mid_rst_csx", 16'(lcd_csx), 16'd1);
    chk("mid_rst_wr_n", 16'(lcd_wr_n), 16'd1);
    chk("mid_rst_dcx", 16'(lcd_dcx), 16'd1);
    chk("mid_rst_done", 16'(cmd_done), 16'd0);
    chk("mid_rst_busy", 16'(busy), 16'd0);
    @(negedge clk);
    rst = 1'b0;
    idle_chk();
    run_req(0, 0, 0, 1, 0);   idle_chk();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
